// File: rtl/inference_job_scheduler_if.sv
// Receive, core and transmit handshake signals of the inference job scheduler.
// The scheduler connects through the master modport; the surrounding
// receive path, inference core and transmit path use the slave modport.
interface inference_job_scheduler_if #(
    parameter int USER_DATA_BYTES = 785,
    parameter int RESULT_WIDTH    = 8
);
    logic [USER_DATA_BYTES*8-1:0] RX_DATA_FRAME;
    logic [31:0]                  RX_SRC_IP_ADDRESS;
    logic [47:0]                  RX_SRC_MAC_ADDRESS;
    logic                         RX_FRAME_READY;

    logic [USER_DATA_BYTES*8-1:0] CORE_FRAME;
    logic                         CORE_START;
    logic                         CORE_DONE;
    logic [RESULT_WIDTH-1:0]      CORE_RESULT;

    logic                         TX_VALID;
    logic                         TX_READY;
    logic [31:0]                  TX_DST_IP_ADDRESS;
    logic [47:0]                  TX_DST_MAC_ADDRESS;
    logic [7:0]                   TX_METADATA;
    logic [RESULT_WIDTH-1:0]      TX_RESULT;

    modport master (
        input  RX_DATA_FRAME, RX_SRC_IP_ADDRESS, RX_SRC_MAC_ADDRESS, RX_FRAME_READY,
        output CORE_FRAME, CORE_START,
        input  CORE_DONE, CORE_RESULT,
        output TX_VALID,
        input  TX_READY,
        output TX_DST_IP_ADDRESS, TX_DST_MAC_ADDRESS, TX_METADATA, TX_RESULT
    );

    modport slave (
        output RX_DATA_FRAME, RX_SRC_IP_ADDRESS, RX_SRC_MAC_ADDRESS, RX_FRAME_READY,
        input  CORE_FRAME, CORE_START,
        output CORE_DONE, CORE_RESULT,
        input  TX_VALID,
        output TX_READY,
        input  TX_DST_IP_ADDRESS, TX_DST_MAC_ADDRESS, TX_METADATA, TX_RESULT
    );
endinterface

// File: rtl/inference_job_scheduler.sv
// Inference job scheduler: 2-slot in-order job queue fed by the receive path,
// one job at a time dispatched to the shared core under a watchdog, result
// handed to the transmit path over valid/ready.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | no job in flight; leaves as soon as the queue is non-empty
//   START     | one-cycle CORE_START pulse, watchdog cleared
//   WAIT_DONE | waiting for CORE_DONE; watchdog expiry drops the job
//   SEND      | TX_VALID held with stable TX_* until TX_READY
module inference_job_scheduler #(
    parameter int USER_DATA_BYTES = 785,
    parameter int RESULT_WIDTH    = 8,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    inference_job_scheduler_if.master bus,
    output logic [1:0]            QUEUE_COUNT,
    output logic [15:0]           DROP_COUNT,
    output logic [15:0]           TIMEOUT_COUNT
);
    localparam int FW   = USER_DATA_BYTES * 8;
    localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, SEND} state_t;

    state_t state, state_nxt;

    logic [FW-1:0]           slot_frame [2];
    logic [31:0]             slot_ip    [2];
    logic [47:0]             slot_mac   [2];
    logic                    wr_ptr, rd_ptr;
    logic [1:0]              count;
    logic [WD_W-1:0]         watchdog;
    logic [31:0]             tx_ip;
    logic [47:0]             tx_mac;
    logic [7:0]              tx_meta;
    logic [RESULT_WIDTH-1:0] tx_result;

    logic core_start, tx_valid, release_job, timeout_hit, done_hit, capture;

    // A full queue still accepts a frame when the head slot frees this cycle;
    // the new frame then lands in the slot being released.
    assign capture = bus.RX_FRAME_READY && ((count != 2'd2) || release_job);

    // State register.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode with Moore handshake outputs and release/latch strobes.
    always_comb begin
        state_nxt   = state;
        core_start  = 1'b0;
        tx_valid    = 1'b0;
        release_job = 1'b0;
        timeout_hit = 1'b0;
        done_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (count != 2'd0) state_nxt = START;
            end
            START: begin
                core_start = 1'b1;
                state_nxt  = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.CORE_DONE) begin
                    done_hit  = 1'b1;
                    state_nxt = SEND;
                end else if (watchdog == WD_LAST) begin
                    release_job = 1'b1;
                    timeout_hit = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                if (bus.TX_READY) begin
                    release_job = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Queue storage, pointers, occupancy and the saturating drop counter.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            for (int i = 0; i < 2; i++) begin
                slot_frame[i] <= '0;
                slot_ip[i]    <= '0;
                slot_mac[i]   <= '0;
            end
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            DROP_COUNT <= '0;
        end else begin
            if (capture) begin
                slot_frame[wr_ptr] <= bus.RX_DATA_FRAME;
                slot_ip[wr_ptr]    <= bus.RX_SRC_IP_ADDRESS;
                slot_mac[wr_ptr]   <= bus.RX_SRC_MAC_ADDRESS;
                wr_ptr             <= ~wr_ptr;
            end else if (bus.RX_FRAME_READY && (DROP_COUNT != 16'hFFFF)) begin
                DROP_COUNT <= DROP_COUNT + 16'd1;
            end
            if (release_job) rd_ptr <= ~rd_ptr;
            case ({capture, release_job})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Watchdog, result capture and the saturating timeout counter.
    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            watchdog      <= '0;
            tx_ip         <= '0;
            tx_mac        <= '0;
            tx_meta       <= '0;
            tx_result     <= '0;
            TIMEOUT_COUNT <= '0;
        end else begin
            if (state == START)          watchdog <= '0;
            else if (state == WAIT_DONE) watchdog <= watchdog + 1'b1;
            if (done_hit) begin
                tx_result <= bus.CORE_RESULT;
                tx_ip     <= slot_ip[rd_ptr];
                tx_mac    <= slot_mac[rd_ptr];
                tx_meta   <= slot_frame[rd_ptr][7:0];
            end
            if (timeout_hit && (TIMEOUT_COUNT != 16'hFFFF))
                TIMEOUT_COUNT <= TIMEOUT_COUNT + 16'd1;
        end
    end

    assign bus.CORE_FRAME         = slot_frame[rd_ptr];
    assign bus.CORE_START         = core_start;
    assign bus.TX_VALID           = tx_valid;
    assign bus.TX_DST_IP_ADDRESS  = tx_ip;
    assign bus.TX_DST_MAC_ADDRESS = tx_mac;
    assign bus.TX_METADATA        = tx_meta;
    assign bus.TX_RESULT          = tx_result;
    assign QUEUE_COUNT            = count;
endmodule

// File: tb/tb_inference_job_scheduler.sv
// Directed bench for inference_job_scheduler with a short watchdog so that
// timeout behaviour is reachable in a few cycles.
module tb_inference_job_scheduler;
    localparam int UDB = 785;
    localparam int RW  = 8;
    localparam int TO  = 16;
    localparam int FW  = UDB * 8;

    logic        ACLK;
    logic        ARESET;
    logic [1:0]  QUEUE_COUNT;
    logic [15:0] DROP_COUNT;
    logic [15:0] TIMEOUT_COUNT;

    int n_tests = 0;
    int n_fail  = 0;

    inference_job_scheduler_if #(.USER_DATA_BYTES(UDB), .RESULT_WIDTH(RW)) bus ();

    inference_job_scheduler #(
        .USER_DATA_BYTES(UDB),
        .RESULT_WIDTH   (RW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK         (ACLK),
        .ARESET       (ARESET),
        .bus          (bus),
        .QUEUE_COUNT  (QUEUE_COUNT),
        .DROP_COUNT   (DROP_COUNT),
        .TIMEOUT_COUNT(TIMEOUT_COUNT)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit");
    end

    function automatic logic [FW-1:0] mk_frame(input logic [7:0] b0, input logic [7:0] tag);
        logic [FW-1:0] f;
        f           = '0;
        f[7:0]      = b0;
        f[15:8]     = tag;
        f[FW-1 -: 8] = tag ^ 8'hFF;
        return f;
    endfunction

    // Advance one clock; sample point is 1 time unit after the rising edge.
    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic rx_pulse(input logic [7:0] b0, input logic [7:0] tag,
                            input logic [31:0] ip, input logic [47:0] mac);
        bus.RX_DATA_FRAME      = mk_frame(b0, tag);
        bus.RX_SRC_IP_ADDRESS  = ip;
        bus.RX_SRC_MAC_ADDRESS = mac;
        bus.RX_FRAME_READY     = 1'b1;
        step();
        bus.RX_FRAME_READY     = 1'b0;
    endtask

    task automatic wait_start(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step();
            if (bus.CORE_START === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        ARESET                 = 1'b0;
        bus.RX_DATA_FRAME      = '0;
        bus.RX_SRC_IP_ADDRESS  = '0;
        bus.RX_SRC_MAC_ADDRESS = '0;
        bus.RX_FRAME_READY     = 1'b0;
        bus.CORE_DONE          = 1'b0;
        bus.CORE_RESULT        = '0;
        bus.TX_READY           = 1'b0;
        #3;
        n_tests++;
        if ({bus.CORE_START, bus.TX_VALID, QUEUE_COUNT, DROP_COUNT, TIMEOUT_COUNT} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: start=%b valid=%b qc=%0d drop=%0d to=%0d, required all 0",
                     bus.CORE_START, bus.TX_VALID, QUEUE_COUNT, DROP_COUNT, TIMEOUT_COUNT);
        end
        n_tests++;
        if ({bus.TX_RESULT, bus.TX_METADATA, bus.TX_DST_IP_ADDRESS, bus.TX_DST_MAC_ADDRESS} !== 96'd0
            || bus.CORE_FRAME !== '0) begin
            n_fail++;
            $display("FAIL reset_data: res=%h meta=%h ip=%h mac=%h, required 0",
                     bus.TX_RESULT, bus.TX_METADATA, bus.TX_DST_IP_ADDRESS, bus.TX_DST_MAC_ADDRESS);
        end
        repeat (2) @(posedge ACLK);
        #1 ARESET = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.CORE_START !== 1'b0 || QUEUE_COUNT !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_idle: start=%b qc=%0d, required 0/0", bus.CORE_START, QUEUE_COUNT);
        end
    endtask

    task automatic test_single_job();
        rx_pulse(8'h05, 8'h11, 32'h0A000002, 48'h001122334455);   // cycle N, now N+1
        n_tests++;
        if (QUEUE_COUNT !== 2'd1 || bus.CORE_START !== 1'b0) begin
            n_fail++;
            $display("FAIL single_capture: qc=%0d start=%b, required 1/0", QUEUE_COUNT, bus.CORE_START);
        end
        step();                                                      // N+2
        n_tests++;
        if (bus.CORE_START !== 1'b1) begin
            n_fail++;
            $display("FAIL single_start_latency: start=%b, required 1", bus.CORE_START);
        end
        n_tests++;
        if (bus.CORE_FRAME !== mk_frame(8'h05, 8'h11)) begin
            n_fail++;
            $display("FAIL single_core_frame: low=%h, required %h", bus.CORE_FRAME[15:0], 16'h1105);
        end
        step();                                                      // N+3
        n_tests++;
        if (bus.CORE_START !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start_width: start=%b, required 0", bus.CORE_START);
        end
        repeat (7) step();                                           // N+10 = M
        bus.CORE_DONE   = 1'b1;
        bus.CORE_RESULT = 8'h07;
        step();                                                      // M+1
        bus.CORE_DONE   = 1'b0;
        bus.CORE_RESULT = 8'h00;
        n_tests++;
        if (bus.TX_VALID !== 1'b1 || bus.TX_DST_IP_ADDRESS !== 32'h0A000002 ||
            bus.TX_DST_MAC_ADDRESS !== 48'h001122334455 || bus.TX_METADATA !== 8'h05 ||
            bus.TX_RESULT !== 8'h07) begin
            n_fail++;
            $display("FAIL single_tx: v=%b ip=%h mac=%h meta=%h res=%h, required 1 0a000002 001122334455 05 07",
                     bus.TX_VALID, bus.TX_DST_IP_ADDRESS, bus.TX_DST_MAC_ADDRESS, bus.TX_METADATA, bus.TX_RESULT);
        end
        step();                                                      // M+2
        bus.TX_READY = 1'b1;
        step();                                                      // M+3 accepted
        bus.TX_READY = 1'b0;
        n_tests++;
        if (bus.TX_VALID !== 1'b0 || QUEUE_COUNT !== 2'd0 || bus.TX_RESULT !== 8'h07) begin
            n_fail++;
            $display("FAIL single_accept: v=%b qc=%0d res=%h, required 0 0 07",
                     bus.TX_VALID, QUEUE_COUNT, bus.TX_RESULT);
        end
    endtask

    task automatic test_queue_full();
        bit seen;
        int starts;
        rx_pulse(8'hA1, 8'h21, 32'hC0A80001, 48'hAAAA00000001);
        rx_pulse(8'hA2, 8'h22, 32'hC0A80002, 48'hAAAA00000002);
        rx_pulse(8'hA3, 8'h23, 32'hC0A80003, 48'hAAAA00000003);     // now N+3, WAIT_DONE
        n_tests++;
        if (QUEUE_COUNT !== 2'd2 || DROP_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL full_drop: qc=%0d drop=%0d, required 2 1", QUEUE_COUNT, DROP_COUNT);
        end
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h31;
        step();
        bus.CORE_DONE = 1'b0;
        n_tests++;
        if (bus.TX_METADATA !== 8'hA1 || bus.TX_DST_IP_ADDRESS !== 32'hC0A80001) begin
            n_fail++;
            $display("FAIL full_order1: meta=%h ip=%h, required a1 c0a80001",
                     bus.TX_METADATA, bus.TX_DST_IP_ADDRESS);
        end
        bus.TX_READY = 1'b1; step(); bus.TX_READY = 1'b0;
        wait_start(seen);
        n_tests++;
        if (!seen || bus.CORE_FRAME !== mk_frame(8'hA2, 8'h22)) begin
            n_fail++;
            $display("FAIL full_order2_start: seen=%b low=%h, required 1 22a2", seen, bus.CORE_FRAME[15:0]);
        end
        step();
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h32;
        step();
        bus.CORE_DONE = 1'b0;
        n_tests++;
        if (bus.TX_METADATA !== 8'hA2 || bus.TX_DST_MAC_ADDRESS !== 48'hAAAA00000002 || bus.TX_RESULT !== 8'h32) begin
            n_fail++;
            $display("FAIL full_order2_tx: meta=%h mac=%h res=%h, required a2 aaaa00000002 32",
                     bus.TX_METADATA, bus.TX_DST_MAC_ADDRESS, bus.TX_RESULT);
        end
        bus.TX_READY = 1'b1; step(); bus.TX_READY = 1'b0;
        starts = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.CORE_START === 1'b1) starts++;
        end
        n_tests++;
        if (starts !== 0 || QUEUE_COUNT !== 2'd0) begin
            n_fail++;
            $display("FAIL full_third_dropped: starts=%0d qc=%0d, required 0 0", starts, QUEUE_COUNT);
        end
    endtask

    task automatic test_simultaneous();
        bit seen;
        rx_pulse(8'hB1, 8'h31, 32'h0B000001, 48'hBBBB00000001);
        rx_pulse(8'hB2, 8'h32, 32'h0B000002, 48'hBBBB00000002);     // N+2, START
        step();                                                      // N+3 WAIT_DONE
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h41;
        step();                                                      // N+4 SEND
        bus.CORE_DONE = 1'b0;
        bus.TX_READY  = 1'b1;
        rx_pulse(8'hB3, 8'h33, 32'h0B000003, 48'hBBBB00000003);     // accepted with release
        bus.TX_READY  = 1'b0;
        n_tests++;
        if (QUEUE_COUNT !== 2'd2 || DROP_COUNT !== 16'd1 || bus.TX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_capture: qc=%0d drop=%0d v=%b, required 2 1 0",
                     QUEUE_COUNT, DROP_COUNT, bus.TX_VALID);
        end
        wait_start(seen);
        n_tests++;
        if (!seen || bus.CORE_FRAME !== mk_frame(8'hB2, 8'h32)) begin
            n_fail++;
            $display("FAIL simul_next_b2: seen=%b low=%h, required 1 32b2", seen, bus.CORE_FRAME[15:0]);
        end
        step();
        bus.CORE_DONE = 1'b1; step(); bus.CORE_DONE = 1'b0;
        bus.TX_READY  = 1'b1; step(); bus.TX_READY  = 1'b0;
        wait_start(seen);
        n_tests++;
        if (!seen || bus.CORE_FRAME !== mk_frame(8'hB3, 8'h33)) begin
            n_fail++;
            $display("FAIL simul_next_b3: seen=%b low=%h, required 1 33b3", seen, bus.CORE_FRAME[15:0]);
        end
        step();
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h43; step(); bus.CORE_DONE = 1'b0;
        n_tests++;
        if (bus.TX_DST_IP_ADDRESS !== 32'h0B000003 || bus.TX_RESULT !== 8'h43) begin
            n_fail++;
            $display("FAIL simul_b3_tx: ip=%h res=%h, required 0b000003 43", bus.TX_DST_IP_ADDRESS, bus.TX_RESULT);
        end
        bus.TX_READY = 1'b1; step(); bus.TX_READY = 1'b0;
        n_tests++;
        if (QUEUE_COUNT !== 2'd0) begin
            n_fail++;
            $display("FAIL simul_drain: qc=%0d, required 0", QUEUE_COUNT);
        end
    endtask

    task automatic test_timeout();
        bit seen;
        int valids;
        rx_pulse(8'hC1, 8'h41, 32'h0C000001, 48'hCCCC00000001);
        wait_start(seen);                                            // cycle S
        valids = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.TX_VALID === 1'b1) valids++;
        end                                                          // S+16, expiry cycle
        n_tests++;
        if (!seen || TIMEOUT_COUNT !== 16'd0 || QUEUE_COUNT !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_before: seen=%b to=%0d qc=%0d, required 1 0 1", seen, TIMEOUT_COUNT, QUEUE_COUNT);
        end
        step();                                                      // S+17
        n_tests++;
        if (TIMEOUT_COUNT !== 16'd1 || QUEUE_COUNT !== 2'd0 || valids !== 0 || bus.TX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_release: to=%0d qc=%0d valids=%0d v=%b, required 1 0 0 0",
                     TIMEOUT_COUNT, QUEUE_COUNT, valids, bus.TX_VALID);
        end
        step();
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'hEE; step(); bus.CORE_DONE = 1'b0;
        step();
        n_tests++;
        if (bus.TX_VALID !== 1'b0 || bus.TX_RESULT !== 8'h43) begin
            n_fail++;
            $display("FAIL timeout_late_done: v=%b res=%h, required 0 43", bus.TX_VALID, bus.TX_RESULT);
        end
        rx_pulse(8'hC2, 8'h42, 32'h0C000002, 48'hCCCC00000002);
        wait_start(seen);                                            // S
        repeat (16) step();                                          // S+16
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h5A;
        step();
        bus.CORE_DONE = 1'b0;
        n_tests++;
        if (!seen || bus.TX_VALID !== 1'b1 || bus.TX_RESULT !== 8'h5A || TIMEOUT_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL timeout_done_priority: seen=%b v=%b res=%h to=%0d, required 1 1 5a 1",
                     seen, bus.TX_VALID, bus.TX_RESULT, TIMEOUT_COUNT);
        end
        bus.TX_READY = 1'b1; step(); bus.TX_READY = 1'b0;
    endtask

    task automatic test_backpressure();
        bit seen;
        int bad;
        logic [31:0] ip0;
        logic [47:0] mac0;
        logic [7:0]  meta0;
        rx_pulse(8'hD1, 8'h51, 32'h0D000001, 48'hDDDD00000001);
        wait_start(seen);
        step();
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h3C;
        step();
        bus.CORE_DONE = 1'b0;
        ip0 = bus.TX_DST_IP_ADDRESS; mac0 = bus.TX_DST_MAC_ADDRESS; meta0 = bus.TX_METADATA;
        n_tests++;
        if (!seen || bus.TX_VALID !== 1'b1 || ip0 !== 32'h0D000001 || meta0 !== 8'hD1) begin
            n_fail++;
            $display("FAIL bp_first_tx: seen=%b v=%b ip=%h meta=%h, required 1 1 0d000001 d1",
                     seen, bus.TX_VALID, ip0, meta0);
        end
        rx_pulse(8'hD2, 8'h52, 32'h0D000002, 48'hDDDD00000002);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.TX_VALID !== 1'b1 || bus.CORE_START !== 1'b0 || bus.TX_RESULT !== 8'h3C ||
                bus.TX_DST_IP_ADDRESS !== ip0 || bus.TX_DST_MAC_ADDRESS !== mac0 ||
                bus.TX_METADATA !== meta0) bad++;
        end
        n_tests++;
        if (bad !== 0 || QUEUE_COUNT !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_hold: unstable_cycles=%0d qc=%0d, required 0 2", bad, QUEUE_COUNT);
        end
        bus.TX_READY = 1'b1; step(); bus.TX_READY = 1'b0;
        n_tests++;
        if (QUEUE_COUNT !== 2'd1 || bus.TX_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: qc=%0d v=%b, required 1 0", QUEUE_COUNT, bus.TX_VALID);
        end
        wait_start(seen);
        n_tests++;
        if (!seen || bus.CORE_FRAME !== mk_frame(8'hD2, 8'h52)) begin
            n_fail++;
            $display("FAIL bp_second_start: seen=%b low=%h, required 1 52d2", seen, bus.CORE_FRAME[15:0]);
        end
        step();
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h3D; step(); bus.CORE_DONE = 1'b0;
        bus.TX_READY  = 1'b1; step(); bus.TX_READY  = 1'b0;
    endtask

    task automatic test_reset_midjob();
        int activity;
        rx_pulse(8'hE1, 8'h61, 32'h0E000001, 48'hEEEE00000001);
        rx_pulse(8'hE2, 8'h62, 32'h0E000002, 48'hEEEE00000002);     // START
        step();
        step();                                                      // WAIT_DONE
        n_tests++;
        if (QUEUE_COUNT !== 2'd2 || TIMEOUT_COUNT !== 16'd1) begin
            n_fail++;
            $display("FAIL rst_pre: qc=%0d to=%0d, required 2 1", QUEUE_COUNT, TIMEOUT_COUNT);
        end
        #2 ARESET = 1'b0;
        #1;
        n_tests++;
        if ({bus.CORE_START, bus.TX_VALID, QUEUE_COUNT, DROP_COUNT, TIMEOUT_COUNT} !== 36'd0 ||
            bus.TX_RESULT !== 8'h00 || bus.TX_DST_IP_ADDRESS !== 32'd0 || bus.CORE_FRAME !== '0) begin
            n_fail++;
            $display("FAIL rst_async: qc=%0d drop=%0d to=%0d res=%h ip=%h, required all 0",
                     QUEUE_COUNT, DROP_COUNT, TIMEOUT_COUNT, bus.TX_RESULT, bus.TX_DST_IP_ADDRESS);
        end
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        step();
        bus.CORE_DONE = 1'b1; bus.CORE_RESULT = 8'h99; step(); bus.CORE_DONE = 1'b0;
        activity = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.TX_VALID === 1'b1 || bus.CORE_START === 1'b1) activity++;
            step();
        end
        n_tests++;
        if (activity !== 0 || QUEUE_COUNT !== 2'd0 || bus.TX_RESULT !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_late_done: activity=%0d qc=%0d res=%h, required 0 0 00",
                     activity, QUEUE_COUNT, bus.TX_RESULT);
        end
    endtask

    initial begin
        test_reset();
        test_single_job();
        test_queue_full();
        test_simultaneous();
        test_timeout();
        test_backpressure();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
